// File: rtl/obj_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obj_table_pkg
// Brief    : Shared state and command encodings for the object table.
// Revision : 1.0 - initial release
// ============================================================================
package obj_table_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_DELALL = 3'd1,
        CMD_DEL    = 3'd2,
        CMD_CRT    = 3'd3,
        CMD_REF    = 3'd4
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/object_table_if.sv
`default_nettype none
// ============================================================================
// Module   : object_table_if
// Brief    : Command/response and map bundle between matrix/clipping units
//            and the object table.
// Revision : 1.0 - initial release
// ============================================================================
interface object_table_if #(
    parameter int NUM_OBJ = 32
);
    localparam int ID_W = $clog2(NUM_OBJ);

    logic               crt_obj;
    logic               del_obj;
    logic               del_all;
    logic               ref_addr;
    logic               changed_in;
    logic [ID_W-1:0]    obj_num;
    logic               dirty_clr;
    logic [ID_W-1:0]    addr;
    logic               addr_vld;
    logic [ID_W-1:0]    lst_stored_obj;
    logic               lst_stored_obj_vld;
    logic               obj_mem_full;
    logic [NUM_OBJ-1:0] obj_map;
    logic [NUM_OBJ-1:0] dirty_map;
    logic [ID_W:0]      obj_count;
    logic               busy;
    logic               cmd_err;

    modport master (
        output crt_obj, del_obj, del_all, ref_addr, changed_in, obj_num, dirty_clr,
        input  addr, addr_vld, lst_stored_obj, lst_stored_obj_vld, obj_mem_full,
               obj_map, dirty_map, obj_count, busy, cmd_err
    );

    modport slave (
        input  crt_obj, del_obj, del_all, ref_addr, changed_in, obj_num, dirty_clr,
        output addr, addr_vld, lst_stored_obj, lst_stored_obj_vld, obj_mem_full,
               obj_map, dirty_map, obj_count, busy, cmd_err
    );

endinterface
`default_nettype wire

// File: rtl/obj_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : obj_prio_enc
// Brief    : Lowest-clear-bit encoder; o_found is low when every bit is set.
// Revision : 1.0 - initial release
// ============================================================================
module obj_prio_enc #(
    parameter int NUM_OBJ = 32,
    parameter int ID_W    = $clog2(NUM_OBJ)
) (
    input  logic [NUM_OBJ-1:0] i_vec,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_found
);

    // Scanning downwards leaves the lowest clear index as the final assignment.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (!i_vec[i]) begin
                o_idx   = ID_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/object_table.sv
`default_nettype none
// ============================================================================
// Module   : object_table
// Brief    : Object-ID allocator mapping IDs to video-memory slots through a
//            circular free-slot FIFO. Define OBJ_TABLE_DIRTY_EN to track a
//            separate dirty map; otherwise dirty_map mirrors obj_map.
// Revision : 1.0 - initial release
// ============================================================================
module object_table
    import obj_table_pkg::*;
#(
    parameter int NUM_OBJ = 32,
    parameter int ID_W    = $clog2(NUM_OBJ)
) (
    input  logic          clk,
    input  logic          rst,
    object_table_if.slave bus
);

    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_OBJ - 1);
    localparam logic [ID_W-1:0] c_one_id  = ID_W'(1);
    localparam logic [ID_W:0]   c_one_cnt = (ID_W+1)'(1);
    localparam logic [ID_W:0]   c_num     = (ID_W+1)'(NUM_OBJ);

    state_t             r_state;
    state_t             w_state_nxt;
    cmd_t               w_cmd;
    logic               w_err;
    logic [2:0]         w_n_cmds;
    logic               w_id_valid;
    logic               w_can_crt;
    logic [ID_W-1:0]    w_free_id;
    logic               w_free_found;

    logic [ID_W-1:0]    r_fifo [NUM_OBJ];
    logic [ID_W-1:0]    r_map  [NUM_OBJ];
    logic [ID_W-1:0]    r_init_cnt;
    logic [ID_W-1:0]    r_head;
    logic [ID_W-1:0]    r_tail;
    logic [ID_W:0]      r_fifo_cnt;
    logic [NUM_OBJ-1:0] r_obj_map;
    logic [ID_W:0]      r_obj_count;
    logic [ID_W-1:0]    r_addr;
    logic               r_addr_vld;
    logic [ID_W-1:0]    r_lst;
    logic               r_lst_vld;
    logic               r_cmd_err;

    obj_prio_enc #(
        .NUM_OBJ (NUM_OBJ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_vec   (r_obj_map),
        .o_idx   (w_free_id),
        .o_found (w_free_found)
    );

    assign w_n_cmds   = 3'(bus.crt_obj) + 3'(bus.del_obj) + 3'(bus.del_all) + 3'(bus.ref_addr);
    assign w_id_valid = r_obj_map[bus.obj_num];
    assign w_can_crt  = w_free_found && (r_fifo_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority resolution: any command that does not execute pulses cmd_err.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd       = CMD_NONE;
        w_err       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_err = (w_n_cmds != 3'd0);
                if (r_init_cnt == c_last_id) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                w_err       = (w_n_cmds != 3'd0);
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_err = (w_n_cmds > 3'd1);
                if (bus.del_all) begin
                    w_cmd       = CMD_DELALL;
                    w_state_nxt = ST_INIT;
                end else if (bus.del_obj) begin
                    if (w_id_valid) begin
                        w_cmd = CMD_DEL;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (bus.crt_obj) begin
                    if (w_can_crt) begin
                        w_cmd       = CMD_CRT;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (bus.ref_addr) begin
                    if (w_id_valid) begin
                        w_cmd       = CMD_REF;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Storage arrays carry no reset; INIT rewrites the FIFO after every reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_fifo[r_init_cnt] <= r_init_cnt;
        end else if (w_cmd == CMD_DEL) begin
            r_fifo[r_tail] <= r_map[bus.obj_num];
        end
        if (w_cmd == CMD_CRT) begin
            r_map[w_free_id] <= r_fifo[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt  <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_fifo_cnt  <= c_num;
            r_obj_map   <= '0;
            r_obj_count <= '0;
            r_addr      <= '0;
            r_addr_vld  <= 1'b0;
            r_lst       <= '0;
            r_lst_vld   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cmd_err  <= w_err;
            r_addr_vld <= (r_state == ST_RESP);
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + c_one_id;
            end
            case (w_cmd)
                CMD_DELALL: begin
                    r_init_cnt  <= '0;
                    r_head      <= '0;
                    r_tail      <= '0;
                    r_fifo_cnt  <= c_num;
                    r_obj_map   <= '0;
                    r_obj_count <= '0;
                    r_lst_vld   <= 1'b0;
                end
                CMD_DEL: begin
                    r_tail                   <= r_tail + c_one_id;
                    r_fifo_cnt               <= r_fifo_cnt + c_one_cnt;
                    r_obj_map[bus.obj_num]   <= 1'b0;
                    r_obj_count              <= r_obj_count - c_one_cnt;
                    if (bus.obj_num == r_lst) begin
                        r_lst_vld <= 1'b0;
                    end
                end
                CMD_CRT: begin
                    r_addr               <= r_fifo[r_head];
                    r_head               <= r_head + c_one_id;
                    r_fifo_cnt           <= r_fifo_cnt - c_one_cnt;
                    r_obj_map[w_free_id] <= 1'b1;
                    r_obj_count          <= r_obj_count + c_one_cnt;
                    r_lst                <= w_free_id;
                    r_lst_vld            <= 1'b1;
                end
                CMD_REF: r_addr <= r_map[bus.obj_num];
                default: ;
            endcase
        end
    end

`ifdef OBJ_TABLE_DIRTY_EN
    logic [NUM_OBJ-1:0] r_dirty;
    logic [NUM_OBJ-1:0] w_dirty_nxt;

    // Clear first so that any set in the same cycle survives.
    always_comb begin
        w_dirty_nxt = bus.dirty_clr ? '0 : r_dirty;
        if (bus.changed_in && w_id_valid && (r_state != ST_INIT)) begin
            w_dirty_nxt[bus.obj_num] = 1'b1;
        end
        if (w_cmd == CMD_DEL) begin
            w_dirty_nxt[bus.obj_num] = 1'b1;
        end
        if (w_cmd == CMD_CRT) begin
            w_dirty_nxt[w_free_id] = 1'b1;
        end
        if ((r_state == ST_INIT) || (w_cmd == CMD_DELALL)) begin
            w_dirty_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_dirty_nxt;
        end
    end

    assign bus.dirty_map = r_dirty;
`else
    logic w_unused_dirty_ctl;

    assign w_unused_dirty_ctl = bus.changed_in ^ bus.dirty_clr;
    assign bus.dirty_map      = r_obj_map;
`endif

    assign bus.addr               = r_addr;
    assign bus.addr_vld           = r_addr_vld;
    assign bus.lst_stored_obj     = r_lst;
    assign bus.lst_stored_obj_vld = r_lst_vld;
    assign bus.obj_mem_full       = (r_obj_count == c_num);
    assign bus.obj_map            = r_obj_map;
    assign bus.obj_count          = r_obj_count;
    assign bus.busy               = (r_state == ST_INIT);
    assign bus.cmd_err            = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_object_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_object_table
// Brief    : Directed bench for object_table at NUM_OBJ=32 and NUM_OBJ=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_object_table;

    // Command bit order: {crt, del, del_all, ref, changed_in, dirty_clr}
    localparam logic [5:0] K_NONE = 6'b000000;
    localparam logic [5:0] K_CRT  = 6'b100000;
    localparam logic [5:0] K_DEL  = 6'b010000;
    localparam logic [5:0] K_DALL = 6'b001000;
    localparam logic [5:0] K_REF  = 6'b000100;
    localparam logic [5:0] K_CHG  = 6'b000010;
    localparam logic [5:0] K_DCLR = 6'b000001;

    typedef struct {
        logic [5:0]  cmd;
        logic [4:0]  num;
        logic        err;
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] map;
        logic [31:0] dirty;
        logic [5:0]  cnt;
        logic [4:0]  lst;
        logic        lvld;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    object_table_if #(.NUM_OBJ(32)) bus32 ();
    object_table_if #(.NUM_OBJ(4))  bus4 ();

    object_table #(.NUM_OBJ(32)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    object_table #(.NUM_OBJ(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive32(input logic [5:0] c, input logic [4:0] n);
        bus32.crt_obj    = c[5];
        bus32.del_obj    = c[4];
        bus32.del_all    = c[3];
        bus32.ref_addr   = c[2];
        bus32.changed_in = c[1];
        bus32.dirty_clr  = c[0];
        bus32.obj_num    = n;
    endtask

    task automatic drive4(input logic [5:0] c, input logic [1:0] n);
        bus4.crt_obj    = c[5];
        bus4.del_obj    = c[4];
        bus4.del_all    = c[3];
        bus4.ref_addr   = c[2];
        bus4.changed_in = c[1];
        bus4.dirty_clr  = c[0];
        bus4.obj_num    = n;
    endtask

    function automatic vec_t mk(input logic [5:0] c, input logic [4:0] n, input logic e,
                                input logic v, input logic [4:0] a, input logic [31:0] m,
                                input logic [31:0] d, input logic [5:0] cn,
                                input logic [4:0] l, input logic lv);
        vec_t r;
        r.cmd = c; r.num = n; r.err = e; r.vld = v; r.addr = a;
        r.map = m; r.dirty = d; r.cnt = cn; r.lst = l; r.lvld = lv;
        return r;
    endfunction

    initial begin
        int n32;
        int n4;
        int nb;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive32(K_NONE, 5'd0);
        drive4(K_NONE, 2'd0);

        //            cmd            num err vld addr map       dirty     cnt lst lvld
        vecs.push_back(mk(K_CRT,        0, 0, 0, 0, 32'h1, 32'h1, 1, 0, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 1, 0, 32'h1, 32'h1, 1, 0, 1));
        vecs.push_back(mk(K_CRT,        0, 0, 0, 0, 32'h3, 32'h3, 2, 1, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 1, 1, 32'h3, 32'h3, 2, 1, 1));
        vecs.push_back(mk(K_CRT,        0, 0, 0, 0, 32'h7, 32'h7, 3, 2, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 1, 2, 32'h7, 32'h7, 3, 2, 1));
        vecs.push_back(mk(K_REF,        1, 0, 0, 0, 32'h7, 32'h7, 3, 2, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 1, 1, 32'h7, 32'h7, 3, 2, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 0, 0, 32'h7, 32'h7, 3, 2, 1));
        vecs.push_back(mk(K_DCLR,       0, 0, 0, 0, 32'h7, 32'h0, 3, 2, 1));
        vecs.push_back(mk(K_CHG|K_DCLR, 2, 0, 0, 0, 32'h7, 32'h4, 3, 2, 1));
        vecs.push_back(mk(K_CHG,        5, 0, 0, 0, 32'h7, 32'h4, 3, 2, 1));
        vecs.push_back(mk(K_DEL,        0, 0, 0, 0, 32'h6, 32'h5, 2, 2, 1));
        vecs.push_back(mk(K_CRT,        0, 0, 0, 0, 32'h7, 32'h5, 3, 0, 1));
        vecs.push_back(mk(K_CRT,        0, 1, 1, 3, 32'h7, 32'h5, 3, 0, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 0, 0, 32'h7, 32'h5, 3, 0, 1));
        vecs.push_back(mk(K_DEL|K_CRT,  1, 1, 0, 0, 32'h5, 32'h7, 2, 0, 1));
        vecs.push_back(mk(K_REF,        1, 1, 0, 0, 32'h5, 32'h7, 2, 0, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 0, 0, 32'h5, 32'h7, 2, 0, 1));
        vecs.push_back(mk(K_DEL,        0, 0, 0, 0, 32'h4, 32'h7, 1, 0, 0));
        vecs.push_back(mk(K_DEL,        0, 1, 0, 0, 32'h4, 32'h7, 1, 0, 0));
        vecs.push_back(mk(K_CRT,        0, 0, 0, 0, 32'h5, 32'h7, 2, 0, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 1, 4, 32'h5, 32'h7, 2, 0, 1));
        vecs.push_back(mk(K_NONE,       0, 0, 0, 0, 32'h5, 32'h7, 2, 0, 1));

        // Reset values held while rst is asserted
        repeat (3) cyc();
        chk("rst_busy",     32'(bus32.busy), 32'd1);
        chk("rst_addr",     32'(bus32.addr), 32'd0);
        chk("rst_addr_vld", 32'(bus32.addr_vld), 32'd0);
        chk("rst_lst",      32'(bus32.lst_stored_obj), 32'd0);
        chk("rst_lst_vld",  32'(bus32.lst_stored_obj_vld), 32'd0);
        chk("rst_full",     32'(bus32.obj_mem_full), 32'd0);
        chk("rst_map",      bus32.obj_map, 32'd0);
        chk("rst_dirty",    bus32.dirty_map, 32'd0);
        chk("rst_count",    32'(bus32.obj_count), 32'd0);
        chk("rst_err",      32'(bus32.cmd_err), 32'd0);

        // busy length after release: edges until busy is seen low
        rst = 1'b0;
        n32 = 0;
        n4  = 0;
        for (int i = 1; i <= 100 && (n32 == 0 || n4 == 0); i++) begin
            cyc();
            if (n32 == 0 && !bus32.busy) n32 = i;
            if (n4 == 0 && !bus4.busy) n4 = i;
        end
        chk("busy_len32", 32'(n32), 32'd32);
        chk("busy_len4",  32'(n4),  32'd4);
        chk("init_map",   bus32.obj_map, 32'd0);
        chk("init_count", 32'(bus32.obj_count), 32'd0);
        chk("init_err",   32'(bus32.cmd_err), 32'd0);

        foreach (vecs[k]) begin
            drive32(vecs[k].cmd, vecs[k].num);
            cyc();
            drive32(K_NONE, 5'd0);
            chk($sformatf("v%0d_err", k),   32'(bus32.cmd_err), 32'(vecs[k].err));
            chk($sformatf("v%0d_vld", k),   32'(bus32.addr_vld), 32'(vecs[k].vld));
            if (vecs[k].vld) chk($sformatf("v%0d_addr", k), 32'(bus32.addr), 32'(vecs[k].addr));
            chk($sformatf("v%0d_map", k),   bus32.obj_map, vecs[k].map);
            chk($sformatf("v%0d_cnt", k),   32'(bus32.obj_count), 32'(vecs[k].cnt));
            chk($sformatf("v%0d_lst", k),   32'(bus32.lst_stored_obj), 32'(vecs[k].lst));
            chk($sformatf("v%0d_lvld", k),  32'(bus32.lst_stored_obj_vld), 32'(vecs[k].lvld));
`ifdef OBJ_TABLE_DIRTY_EN
            chk($sformatf("v%0d_dirty", k), bus32.dirty_map, vecs[k].dirty);
`else
            chk($sformatf("v%0d_dirty", k), bus32.dirty_map, vecs[k].map);
`endif
        end

        // Small table: fill to full, overflow, then delete-all
        for (int i = 0; i < 4; i++) begin
            drive4(K_CRT, 2'd0);
            cyc();
            drive4(K_NONE, 2'd0);
            cyc();
            chk($sformatf("d4_crt%0d_vld", i),  32'(bus4.addr_vld), 32'd1);
            chk($sformatf("d4_crt%0d_addr", i), 32'(bus4.addr), 32'(i));
            chk($sformatf("d4_crt%0d_full", i), 32'(bus4.obj_mem_full), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("d4_map_full", 32'(bus4.obj_map), 32'hF);
        chk("d4_cnt_full", 32'(bus4.obj_count), 32'd4);
        chk("d4_lst",      32'(bus4.lst_stored_obj), 32'd3);

        drive4(K_CRT, 2'd0);
        cyc();
        drive4(K_NONE, 2'd0);
        chk("d4_over_err", 32'(bus4.cmd_err), 32'd1);
        chk("d4_over_map", 32'(bus4.obj_map), 32'hF);
        chk("d4_over_cnt", 32'(bus4.obj_count), 32'd4);
        cyc();
        chk("d4_over_err_end", 32'(bus4.cmd_err), 32'd0);
        chk("d4_over_novld",   32'(bus4.addr_vld), 32'd0);

        drive4(K_CHG | K_DCLR, 2'd2);
        cyc();
        drive4(K_NONE, 2'd0);
`ifdef OBJ_TABLE_DIRTY_EN
        chk("d4_dirty_set_wins", 32'(bus4.dirty_map), 32'h4);
`else
        chk("d4_dirty_set_wins", 32'(bus4.dirty_map), 32'hF);
`endif

        drive4(K_DALL, 2'd0);
        cyc();
        drive4(K_NONE, 2'd0);
        chk("d4_dall_busy",  32'(bus4.busy), 32'd1);
        chk("d4_dall_map",   32'(bus4.obj_map), 32'd0);
        chk("d4_dall_dirty", 32'(bus4.dirty_map), 32'd0);
        chk("d4_dall_cnt",   32'(bus4.obj_count), 32'd0);
        chk("d4_dall_full",  32'(bus4.obj_mem_full), 32'd0);
        chk("d4_dall_lvld",  32'(bus4.lst_stored_obj_vld), 32'd0);

        drive4(K_REF, 2'd0);
        cyc();
        drive4(K_NONE, 2'd0);
        chk("d4_init_ref_err", 32'(bus4.cmd_err), 32'd1);
        chk("d4_init_busy",    32'(bus4.busy), 32'd1);

        // Two of the four busy cycles have elapsed; two remain
        nb = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (!bus4.busy) begin
                nb = i;
                break;
            end
        end
        chk("d4_dall_busy_rest", 32'(nb), 32'd3);

        drive4(K_CRT, 2'd0);
        cyc();
        drive4(K_NONE, 2'd0);
        cyc();
        chk("d4_recrt_vld",  32'(bus4.addr_vld), 32'd1);
        chk("d4_recrt_addr", 32'(bus4.addr), 32'd0);
        chk("d4_recrt_map",  32'(bus4.obj_map), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/object_table.md
# object_table

Parametrised successor to the object unit: it tracks which logical object IDs exist and maps each one to a physical video-memory slot. Free slots are held in a circular free-address FIFO, so deleted slots are recycled. It sits between the matrix unit, which issues create/delete/reference commands and consumes the returned address, and the clipping unit, which consumes the occupancy and dirty maps.

## Interface
Parameters:
- NUM_OBJ, 32: number of object IDs and memory slots; power of two, ≥2.
- ID_W, $clog2(NUM_OBJ): width of IDs and addresses; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- crt_obj  in  1  create pulse.
- del_obj  in  1  delete obj_num pulse.
- del_all  in  1  delete all objects.
- ref_addr  in  1  look up the address of obj_num.
- changed_in  in  1  obj_num has been rewritten; mark it dirty.
- obj_num  in  ID_W  target ID for del_obj, ref_addr and changed_in.
- dirty_clr  in  1  clipper consumed the dirty map; clear it.
- addr  out  ID_W  physical slot; meaningful only while addr_vld is high.
- addr_vld  out  1  one-cycle pulse qualifying addr.
- lst_stored_obj  out  ID_W  ID of the most recent successful create.
- lst_stored_obj_vld  out  1  lst_stored_obj still exists.
- obj_mem_full  out  1  all IDs are in use.
- obj_map  out  NUM_OBJ  bit i set ⇔ ID i exists.
- dirty_map  out  NUM_OBJ  IDs needing a redraw.
- obj_count  out  ID_W+1  number of live objects.
- busy  out  1  table initialising; commands are refused.
- cmd_err  out  1  one-cycle pulse: the command was refused.

## Operation
- States: INIT, IDLE, RESP.
- INIT: entered on rst and on an accepted del_all. Writes fifo[i]=i for one i per cycle, NUM_OBJ cycles in total. Clears obj_map, dirty_map, lst_stored_obj_vld and obj_count. Then goes to IDLE.
- Commands are sampled only in IDLE. A command asserted in INIT or RESP is dropped and pulses cmd_err.
- Same-cycle commands resolve by priority del_all > del_obj > crt_obj > ref_addr. The winner executes; any loser pulses cmd_err.
- crt_obj:
  - ID = lowest clear bit of obj_map.
  - addr = FIFO pop; the map table records id→addr.
  - Sets obj_map[ID] and dirty[ID]; lst_stored_obj=ID, lst_stored_obj_vld=1; obj_count+1.
  - Goes to RESP.
  - When obj_mem_full: no state change, cmd_err pulse.
- del_obj with a valid ID:
  - Pushes map[ID] to the FIFO tail; clears obj_map[ID]; sets dirty[ID]; obj_count−1.
  - If ID == lst_stored_obj, clears lst_stored_obj_vld.
  - Stays in IDLE.
  - With an invalid ID: cmd_err pulse.
- ref_addr with a valid ID: addr = map[ID], goes to RESP. With an invalid ID: cmd_err pulse, stays in IDLE.
- RESP: addr_vld=1 for exactly one cycle, then returns to IDLE.
- changed_in: sets dirty[obj_num] if that ID is valid, otherwise it is ignored. It is honoured in every state except INIT. It is not part of command priority.
- dirty_clr: clears all dirty bits. A dirty set in the same cycle wins for that bit.
- obj_mem_full = (obj_count == NUM_OBJ).
- The FIFO count is ID_W+1 bits wide; the head and tail pointers are ID_W bits and wrap modulo NUM_OBJ.

## Timing
- Reset values: addr=0, addr_vld=0, lst_stored_obj=0, lst_stored_obj_vld=0, obj_mem_full=0, obj_map=0, dirty_map=0, obj_count=0, cmd_err=0, busy=1.
- busy stays high while rst is high and for NUM_OBJ cycles after its release. It falls on the cycle the state becomes IDLE.
- rst mid-operation aborts everything, including RESP and INIT, and restarts INIT.
- crt_obj and ref_addr: command sampled at edge N; addr and addr_vld valid after edge N+1. For crt_obj, obj_map, lst_stored_obj and obj_count are already updated after edge N+1.
- The earliest next command is at edge N+2; a command at edge N+1 pulses cmd_err.
- del_obj: obj_map and obj_count update after edge N. The next command can be accepted at edge N+1.
- cmd_err pulses after the same edge that sampled the refused command.
- A del_all at edge N makes busy high after edge N, for NUM_OBJ cycles.

## Configuration
- OBJ_TABLE_DIRTY_EN defined: dirty_map is tracked as described above.
- Undefined:
  - The dirty register is not built; dirty_map is tied to obj_map, so the clipper redraws every live object.
  - changed_in and dirty_clr are ignored.

## Structure
- obj_table_pkg holds the state enum (ST_INIT, ST_IDLE, ST_RESP) and the command enum (CMD_NONE, CMD_DELALL, CMD_DEL, CMD_CRT, CMD_REF).
- Sub-module obj_prio_enc: parametrised lowest-clear-bit encoder over NUM_OBJ bits. Outputs the index and a found flag.

## Test plan
- Reset, NUM_OBJ=32: busy is high for 32 cycles after rst falls, then low. All other outputs keep their reset values.
- Three creates: IDs 0, 1, 2 get addrs 0, 1, 2. obj_map=0x7, obj_count=3, lst_stored_obj=2. Then ref_addr on obj 1 → addr=1 with a one-cycle addr_vld pulse.
- Delete obj 0, then create: the new object gets ID 0 and addr 3 (FIFO order). The freed addr 0 sits at the FIFO tail.
- NUM_OBJ=4: four creates set obj_mem_full=1. A fifth create → cmd_err pulse; obj_map stays 0xF.
- del_obj and crt_obj in the same cycle: the delete executes and cmd_err pulses. A ref_addr on a deleted ID → cmd_err with no addr_vld.
- With OBJ_TABLE_DIRTY_EN: changed_in on obj 2 together with dirty_clr leaves dirty_map=0x4. A del_all mid-sequence → busy for 4 cycles, then all maps are 0.
